wave_seq_ctrl: RTL and testbench

- Sequencer for the waveform sample-address datapath.
- Generates the sample-memory address and paces it at a programmable rate (clock ticks per sample).
- Runs a programmed number of waveform periods, or runs continuously, under start/stop control.
- Sits between the control registers and the sample memory / DAC path. Replaces free-running `up` pulsing with a deterministic, true-modulo-N address sequence.

---
 rtl/wave_seq_ctrl_pkg.sv | 26 ++
 rtl/wave_seq_ctrl_if.sv | 31 +++
 rtl/wave_seq_ctrl_sample_tick.sv | 29 ++
 rtl/wave_seq_ctrl.sv | 113 +++++++++++
 tb/tb_wave_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_seq_ctrl_pkg.sv
// Shared types and helpers for the waveform sample-address sequencer.
package wave_seq_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wave_seq_ctrl_if.sv
// Control/status bundle between the register block (master) and the sequencer (slave).
interface wave_seq_ctrl_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
);
  import wave_seq_pkg::*;

  // start/stop are levels sampled on every clk edge; there is no handshake back.
  // sample_en, period_end and done are single-cycle pulses; busy is a level.
  logic              start;
  logic              stop;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  periods;
  logic [ADDR_W-1:0] address;
  logic              sample_en;
  logic              period_end;
  logic              busy;
  logic              done;
  state_t            state;

  modport master (
    output start, stop, div, periods,
    input  address, sample_en, period_end, busy, done, state
  );

  modport slave (
    input  start, stop, div, periods,
    output address, sample_en, period_end, busy, done, state
  );

endinterface

// File: rtl/wave_seq_ctrl_sample_tick.sv
// Loadable rate divider: tick is asserted while enabled and the count has reached zero.
module sample_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  input  logic             enable,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] count;

  assign tick = enable && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable) begin
      count <= (count == '0) ? value : count - ONE;
    end
  end

endmodule

// File: rtl/wave_seq_ctrl.sv
// Waveform sample-address sequencer: modulo-N address, paced by a divider, for a set number of periods.
module wave_seq_ctrl
  import wave_seq_pkg::*;
#(
  parameter int N     = 3,
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  wave_seq_ctrl_if.slave bus
);

  localparam int               AW    = (clogb2(N) < 1) ? 1 : clogb2(N);
  localparam logic [AW-1:0]    LAST  = AW'(N - 1);
  localparam logic [AW-1:0]    ONE_A = AW'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] per_q;
  logic [DIV_W-1:0] div_q;
  logic             se_q, se_d, pe_q, pe_d, busy_q, busy_d, done_q, done_d;
  logic             accept, tick, wrap, finish;

  assign accept = (state == IDLE) && bus.start && !bus.stop;
  assign wrap   = tick && (addr_q == LAST);
  assign finish = wrap && (per_q != '0) && ((pcnt_q + ONE_C) == per_q);

  // The load value comes straight from the port at start; reloads use the latched copy.
  sample_tick #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .value  (accept ? bus.div : div_q),
    .enable (state == RUN),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      pcnt_q <= '0;
      per_q  <= '0;
      div_q  <= '0;
      se_q   <= 1'b0;
      pe_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      addr_q <= addr_d;
      pcnt_q <= pcnt_d;
      se_q   <= se_d;
      pe_q   <= pe_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept) begin
        div_q <= bus.div;
        per_q <= bus.periods;
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (bus.stop || finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // stop outranks a coincident tick, so it is tested first.
  always_comb begin
    addr_d = addr_q;
    pcnt_d = pcnt_q;
    busy_d = busy_q;
    se_d   = 1'b0;
    pe_d   = 1'b0;
    done_d = 1'b0;
    if (state == IDLE) begin
      addr_d = '0;
      busy_d = accept;
      if (accept) pcnt_d = '0;
    end else if (bus.stop) begin
      addr_d = '0;
      busy_d = 1'b0;
    end else if (tick) begin
      se_d   = 1'b1;
      addr_d = wrap ? '0 : addr_q + ONE_A;
      if (wrap) begin
        pe_d = 1'b1;
        if (pcnt_q != '1) pcnt_d = pcnt_q + ONE_C;
      end
      if (finish) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        addr_d = '0;
      end
    end
  end

  assign bus.address    = ADDR_W'(addr_q);
  assign bus.sample_en  = se_q;
  assign bus.period_end = pe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Bench for wave_seq_ctrl: four instances (N=3,4,1,5), an arithmetic run-time model and directed runs.
module tb_wave_seq_ctrl;

  function automatic int nval(input int g);
    case (g)
      0: return 3;
      1: return 4;
      2: return 1;
      default: return 5;
    endcase
  endfunction

  logic clk;
  logic rst;

  logic        start_v [4];
  logic        stop_v  [4];
  logic [15:0] div_v   [4];
  logic [7:0]  per_v   [4];
  logic [11:0] addr_v  [4];
  logic        se_v    [4];
  logic        pe_v    [4];
  logic        busy_v  [4];
  logic        done_v  [4];

  wave_seq_ctrl_if #(.DIV_W(16), .CNT_W(8)) bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wave_seq_ctrl #(.N(nval(g)), .DIV_W(16), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
    assign bus[g].start   = start_v[g];
    assign bus[g].stop    = stop_v[g];
    assign bus[g].div     = div_v[g];
    assign bus[g].periods = per_v[g];
    assign addr_v[g]      = bus[g].address;
    assign se_v[g]        = bus[g].sample_en;
    assign pe_v[g]        = bus[g].period_end;
    assign busy_v[g]      = bus[g].busy;
    assign done_v[g]      = bus[g].done;
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since start t; every (div+1)th edge is sample k=t/(div+1);
  // address = k mod N, wrap when k mod N == 0, done when k == N*periods.
  bit          run_m [4];
  int          t_m   [4];
  int          dv_m  [4];
  int          pr_m  [4];
  logic [11:0] ea    [4];
  logic        ese   [4];
  logic        epe   [4];
  logic        ebusy [4];
  logic        edone [4];

  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 4; g++) begin
      int t;
      int k;
      if (rst) begin
        run_m[g] <= 1'b0;
        t_m[g]   <= 0;
        ea[g]    <= '0;
        ese[g]   <= 1'b0;
        epe[g]   <= 1'b0;
        ebusy[g] <= 1'b0;
        edone[g] <= 1'b0;
      end else begin
        ese[g]   <= 1'b0;
        epe[g]   <= 1'b0;
        edone[g] <= 1'b0;
        if (!run_m[g]) begin
          ea[g] <= '0;
          if (start_v[g] && !stop_v[g]) begin
            run_m[g] <= 1'b1;
            t_m[g]   <= 0;
            dv_m[g]  <= int'(div_v[g]);
            pr_m[g]  <= int'(per_v[g]);
            ebusy[g] <= 1'b1;
          end else begin
            ebusy[g] <= 1'b0;
          end
        end else if (stop_v[g]) begin
          run_m[g] <= 1'b0;
          ebusy[g] <= 1'b0;
          ea[g]    <= '0;
        end else begin
          t = t_m[g] + 1;
          t_m[g] <= t;
          if (t % (dv_m[g] + 1) == 0) begin
            k = t / (dv_m[g] + 1);
            ese[g] <= 1'b1;
            ea[g]  <= 12'(k % nval(g));
            if (k % nval(g) == 0) epe[g] <= 1'b1;
            if (pr_m[g] != 0 && k == nval(g) * pr_m[g]) begin
              edone[g] <= 1'b1;
              ebusy[g] <= 1'b0;
              run_m[g] <= 1'b0;
              ea[g]    <= '0;
            end
          end
        end
      end
    end
  end

  // scoreboard compare, every cycle, all instances
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("m_addr%0d", g), 32'(addr_v[g]), 32'(ea[g]));
      chk($sformatf("m_se%0d", g),   32'(se_v[g]),   32'(ese[g]));
      chk($sformatf("m_pe%0d", g),   32'(pe_v[g]),   32'(epe[g]));
      chk($sformatf("m_busy%0d", g), 32'(busy_v[g]), 32'(ebusy[g]));
      chk($sformatf("m_done%0d", g), 32'(done_v[g]), 32'(edone[g]));
    end
  end

  task automatic start_run(input int g, input int d, input int p);
    @(negedge clk);
    start_v[g] = 1'b1;
    div_v[g]   = 16'(d);
    per_v[g]   = 8'(p);
    @(posedge clk);
    #2;
    chk("start_busy", 32'(busy_v[g]), 1);
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic stop_run(input int g);
    @(negedge clk);
    stop_v[g] = 1'b1;
    @(posedge clk);
    #2;
    chk("stop_addr", 32'(addr_v[g]), 0);
    chk("stop_busy", 32'(busy_v[g]), 0);
    @(negedge clk);
    stop_v[g] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      start_v[g] = 1'b0;
      stop_v[g]  = 1'b0;
      div_v[g]   = '0;
      per_v[g]   = '0;
    end
    #1;
    chk("rst_addr", 32'(addr_v[0]), 0);
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_se",   32'(se_v[0]),   0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // N=3, div=1, periods=2
    start_run(0, 1, 2);
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk);
      #2;
      chk("t1_se",   32'(se_v[0]),   32'(e % 2 == 0 && e <= 12));
      chk("t1_pe",   32'(pe_v[0]),   32'(e == 6 || e == 12));
      chk("t1_done", 32'(done_v[0]), 32'(e == 12));
      chk("t1_busy", 32'(busy_v[0]), 32'(e < 12));
      if (e == 2)  chk("t1_addr_e2", 32'(addr_v[0]), 1);
      if (e == 4)  chk("t1_addr_e4", 32'(addr_v[0]), 2);
      if (e == 6)  chk("t1_addr_e6", 32'(addr_v[0]), 0);
      if (e == 8)  chk("t1_addr_e8", 32'(addr_v[0]), 1);
      if (e == 10) chk("t1_addr_e10", 32'(addr_v[0]), 2);
    end

    // N=4, div=0, continuous, beyond counter saturation
    start_run(1, 0, 0);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #2;
      chk("t2_addr", 32'(addr_v[1]), 32'(e % 4));
      chk("t2_se",   32'(se_v[1]),   1);
      chk("t2_pe",   32'(pe_v[1]),   32'(e == 4));
    end
    repeat (1200) @(posedge clk);
    #2;
    chk("t2_busy_300", 32'(busy_v[1]), 1);
    stop_run(1);

    // N=3, div=2, periods=1, stop on the edge of the 2nd tick
    start_run(0, 2, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("t3_addr_e3", 32'(addr_v[0]), 1);
    chk("t3_se_e3",   32'(se_v[0]),   1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    stop_v[0] = 1'b1;
    @(posedge clk);
    #2;
    chk("t3_se",   32'(se_v[0]),   0);
    chk("t3_done", 32'(done_v[0]), 0);
    chk("t3_addr", 32'(addr_v[0]), 0);
    chk("t3_busy", 32'(busy_v[0]), 0);
    @(negedge clk);
    stop_v[0] = 1'b0;

    // start+stop in IDLE, then div change mid-run
    @(negedge clk);
    start_v[0] = 1'b1;
    stop_v[0]  = 1'b1;
    div_v[0]   = 16'd1;
    per_v[0]   = 8'd0;
    @(posedge clk);
    #2;
    chk("t4_busy_both", 32'(busy_v[0]), 0);
    chk("t4_addr_both", 32'(addr_v[0]), 0);
    @(negedge clk);
    stop_v[0] = 1'b0;
    @(posedge clk);
    #2;
    chk("t4_busy", 32'(busy_v[0]), 1);
    @(negedge clk);
    start_v[0] = 1'b0;
    div_v[0]   = 16'd5;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #2;
      chk("t4_se", 32'(se_v[0]), 32'(e % 2 == 0));
    end
    stop_run(0);

    // N=1, div=3, periods=3, immediate restart
    start_run(2, 3, 3);
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #2;
      chk("t5_addr", 32'(addr_v[2]), 0);
      chk("t5_se",   32'(se_v[2]),   32'(e % 4 == 0));
      chk("t5_pe",   32'(pe_v[2]),   32'(e % 4 == 0));
      chk("t5_done", 32'(done_v[2]), 32'(e == 12));
    end
    start_run(2, 3, 3);
    stop_run(2);

    // N=5, async reset mid-run at address 3
    start_run(3, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("t6_addr3", 32'(addr_v[3]), 3);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_addr", 32'(addr_v[3]), 0);
    chk("t6_rst_busy", 32'(busy_v[3]), 0);
    chk("t6_rst_se",   32'(se_v[3]),   0);
    chk("t6_rst_pe",   32'(pe_v[3]),   0);
    chk("t6_rst_done", 32'(done_v[3]), 0);
    @(negedge clk);
    rst = 1'b0;
    start_run(3, 0, 0);
    @(posedge clk);
    #2;
    chk("t6_restart_addr", 32'(addr_v[3]), 1);
    chk("t6_restart_busy", 32'(busy_v[3]), 1);
    stop_run(3);

    repeat (2) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
